// File: rtl/restoring_divider_seq_pkg.sv
// restoring_divider_seq_pkg: shared state encoding and default operand width for the divider
package restoring_divider_seq_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/restoring_divider_seq_ripple_subtractor.sv
// ripple_subtractor: N-bit a-b-borrow_in built from a chain of full_subtractor cells
module ripple_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic [N-1:0] diff,
    output logic         borrow_out
);
    logic [N:0] w_b;
    assign w_b[0] = borrow_in;
    for (genvar i = 0; i < N; i++) begin : g_full_subtractor
        assign diff[i]  = a[i] ^ b[i] ^ w_b[i];
        assign w_b[i+1] = (~a[i] & b[i]) | (w_b[i] & ~(a[i] ^ b[i]));
    end
    assign borrow_out = w_b[N];
endmodule

// File: rtl/restoring_divider_seq.sv
// restoring_divider_seq: iterative unsigned restoring divider, one quotient bit per clock
module restoring_divider_seq
    import restoring_divider_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    state_t           r_state, w_next;
    logic [WIDTH:0]   r_r, w_rs, w_t, w_rn;
    logic [WIDTH-1:0] r_q, r_d, w_qn, r_quot, r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_busy, r_done, r_dz, w_bo, w_accept, w_dz, w_last;
    // R's top bit is always 0 between iterations, so the shift drops it
    assign w_rs     = (WIDTH+1)'({r_r, r_q} >> (WIDTH - 1));
    assign w_rn     = w_bo ? w_rs : w_t;
    assign w_qn     = {r_q[WIDTH-2:0], ~w_bo};
    assign w_accept = start && (r_state != S_RUN);
    assign w_dz     = divisor == '0;
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    ripple_subtractor #(.N(WIDTH + 1)) u_sub (
        .a         (w_rs),
        .b         ({1'b0, r_d}),
        .borrow_in (1'b0),
        .diff      (w_t),
        .borrow_out(w_bo)
    );
    always_comb begin
        w_next = r_state == S_RUN ? (w_last ? S_DONE : S_RUN)
               : w_accept         ? (w_dz ? S_DONE : S_RUN)
               : S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_d     <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next == S_RUN;
            r_done  <= w_next == S_DONE;
            if (r_state == S_RUN) begin
                r_r   <= w_rn;
                r_q   <= w_qn;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_quot <= w_qn;
                    r_rem  <= w_rn[WIDTH-1:0];
                end
            end else if (w_accept) begin
                r_dz <= w_dz;
                if (w_dz) begin
                    r_quot <= '1;
                    r_rem  <= dividend;
                end else begin
                    r_d   <= divisor;
                    r_r   <= '0;
                    r_q   <= dividend;
                    r_cnt <= '0;
                end
            end
        end
    end
    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;
endmodule

// File: doc/restoring_divider_seq.md
Name: restoring_divider_seq

Overview:
Multi-cycle unsigned integer divider built on the team's ripple-carry arithmetic cells. It is the inverse operation of the full_adder/full_adder_4bit path: subtraction with a borrow chain instead of addition with a carry chain.
Uses restoring shift-subtract, one quotient bit per clock, with a start/busy/done handshake. Sits next to the adder in the arithmetic library as the iterative datapath block.

Parameters:
WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder (legal range 2..16)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request a division; sampled only when the block is in IDLE or DONE
dividend  input  WIDTH  unsigned numerator; sampled on the accepting edge only
divisor  input  WIDTH  unsigned denominator; sampled on the accepting edge only
busy  output  1  high while an operation is in progress (LOAD/RUN)
done  output  1  one-cycle pulse; quotient and remainder are valid while it is high
quotient  output  WIDTH  result quotient, held until the next accepted start
remainder  output  WIDTH  result remainder, held until the next accepted start
div_by_zero  output  1  set with done when divisor==0, held with the results

Behaviour:
- Reset: clk edge with rst=1 forces state=IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- rst has priority over start and over everything else, including mid-RUN. A partial result is discarded and never reaches the outputs.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE/DONE + start=1:
  - divisor!=0: latch divisor; set partial remainder R=0 ((WIDTH+1) bits) and shift register Q=dividend; count=0; go to RUN; busy=1; div_by_zero=0.
  - divisor==0: go directly to DONE on the same edge. quotient=all ones, remainder=dividend, div_by_zero=1, done=1, busy=0.
- RUN, each edge:
  - {R,Q} shifted left 1; T = R_shifted - {1'b0,divisor} over WIDTH+1 bits, borrow-ripple.
  - If no borrow out: R=T and Q[0]=1. Otherwise R is restored (kept) and Q[0]=0.
  - count increments. After the WIDTH-th iteration (count==WIDTH-1 on that edge): go to DONE, quotient=Q, remainder=R[WIDTH-1:0], done=1, busy=0.
- Latency: start accepted at edge E0 gives done=1 in the cycle after edge E0+WIDTH, so WIDTH+1 edges from acceptance. busy is high for exactly WIDTH cycles. Divide-by-zero: done in the cycle after E0.
- DONE lasts exactly one cycle, then goes to IDLE (done back to 0) unless start=1 in that cycle. In that case a new operation is accepted back-to-back.
- start while busy=1 is ignored; the operand inputs are don't-care during RUN.
- Outputs hold their last values in IDLE and RUN. quotient/remainder change only on a DONE entry or on reset.
- Invariant checked in RUN/DONE: dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared package/header: state encoding constants (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and the default WIDTH constant. The bench reuses both.
- One sub-module: ripple_subtractor. It is parameterised to WIDTH+1 bits and built from full_subtractor cells (diff = a^b^bin; bout = (~a&b)|(bin&~(a^b))), mirroring the full_adder chain. Outputs are diff and borrow_out.
- The FSM, counter, and R/Q registers stay in restoring_divider_seq.

Test Plan:
- WIDTH=4, dividend=13, divisor=4, single start -> busy high 4 cycles; done pulse at E0+5; quotient=3, remainder=1, div_by_zero=0.
- dividend=9, divisor=0 -> done in the next cycle, busy never high; quotient=4'b1111, remainder=9, div_by_zero=1.
- dividend=3, divisor=7 -> quotient=0, remainder=3. dividend=15, divisor=1 -> quotient=15, remainder=0.
- Start 12/5, assert rst on the 2nd RUN cycle -> next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse ever follows.
- Start 14/3, pulse start=1 with 7/2 during RUN -> ignored, result 4 rem 2. Start 7/2 during the DONE cycle -> accepted back-to-back, result 3 rem 1 at the next done.
- Exhaustive: all 16x16 dividend/divisor pairs, each start issued in the DONE cycle of the previous one -> every result matches a reference model (/ and %, divide-by-zero rule); 256 done pulses in total.
